// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: PC register handshake, instruction-memory port, decode slot and redirects.
// master is the fetch controller side; slave is the PC register / memory / decode side.
interface fetch_ctrl_if;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_stall;
  logic        exc;
  logic        eret;
  logic [31:0] epc;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        br_taken;
  logic [31:0] br_target;

  modport master (
    input  pc, imem_ack, imem_rdata, id_stall, exc, eret, epc, jmp, jmp_target,
           br_taken, br_target,
    output next_pc, pc_stall, imem_req, imem_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output pc, imem_ack, imem_rdata, id_stall, exc, eret, epc, jmp, jmp_target,
           br_taken, br_target,
    input  next_pc, pc_stall, imem_req, imem_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, a decode slot backed by a
// single skid entry, and redirect handling that discards in-flight data.
module fetch_ctrl #(
  parameter logic [31:0] ResetVector = 32'h0000_0000,
  parameter logic [31:0] ExcVector   = 32'h0000_0080
) (
  input logic         clk,
  input logic         rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StBoot, StReq, StDrop} state_e;

  state_e      state_q;
  logic        slot_valid_q, skid_valid_q;
  logic [31:0] slot_instr_q, slot_pc_q, skid_instr_q, skid_pc_q, drop_tgt_q;

  logic        redirect, consume, req, ack;
  logic [31:0] redir_tgt;

  always_comb begin
    redirect = (state_q != StBoot) && (bus.exc || bus.eret || bus.jmp || bus.br_taken);
    if (bus.exc)       redir_tgt = ExcVector;
    else if (bus.eret) redir_tgt = bus.epc;
    else if (bus.jmp)  redir_tgt = bus.jmp_target;
    else               redir_tgt = bus.br_target;
    consume = slot_valid_q && !bus.id_stall;
    // A pending skid entry blocks new requests; DROP keeps the abandoned one alive until ack.
    req     = ((state_q == StReq) && !skid_valid_q) || (state_q == StDrop);
    ack     = req && bus.imem_ack;
  end

  always_comb begin
    bus.imem_req  = req;
    bus.imem_addr = bus.pc;
    bus.if_valid  = slot_valid_q;
    bus.if_instr  = slot_instr_q;
    bus.if_pc     = slot_pc_q;
    bus.next_pc   = bus.pc + 32'd4;
    bus.pc_stall  = 1'b1;
    unique case (state_q)
      StBoot: begin
        bus.next_pc  = ResetVector;
        bus.pc_stall = 1'b0;
      end
      StReq: begin
        if (redirect && (!req || ack)) begin
          bus.next_pc  = redir_tgt;
          bus.pc_stall = 1'b0;
        end else if (ack && !redirect) begin
          bus.pc_stall = 1'b0;
        end
      end
      StDrop: begin
        if (ack) begin
          bus.next_pc  = redirect ? redir_tgt : drop_tgt_q;
          bus.pc_stall = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StBoot;
      slot_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      slot_instr_q <= '0;
      slot_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      drop_tgt_q   <= '0;
    end else begin
      case (state_q)
        StBoot: state_q <= StReq;
        StReq: begin
          if (redirect && req && !ack) begin
            state_q    <= StDrop;
            drop_tgt_q <= redir_tgt;
          end
        end
        StDrop: begin
          if (ack)           state_q    <= StReq;
          else if (redirect) drop_tgt_q <= redir_tgt;
        end
        default: state_q <= StBoot;
      endcase

      if (redirect) begin
        slot_valid_q <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (skid_valid_q) begin
        if (consume) begin
          slot_instr_q <= skid_instr_q;
          slot_pc_q    <= skid_pc_q;
          skid_valid_q <= 1'b0;
        end
      end else if ((state_q == StReq) && ack) begin
        if (!slot_valid_q || consume) begin
          slot_instr_q <= bus.imem_rdata;
          slot_pc_q    <= bus.pc;
          slot_valid_q <= 1'b1;
        end else begin
          skid_instr_q <= bus.imem_rdata;
          skid_pc_q    <= bus.pc;
          skid_valid_q <= 1'b1;
        end
      end else if (consume) begin
        slot_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and latency-randomised memory models, directed scenarios,
// and a scoreboard that checks the instruction stream delivered to decode.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  fetch_ctrl_if bus();

  fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_consumed = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // PC register
  always @(posedge clk or posedge rst) begin
    if (rst)               bus.pc <= 32'h0;
    else if (!bus.pc_stall) bus.pc <= bus.next_pc;
  end

  // Instruction memory: per-request latency, optional slow address, optional stray ack.
  int unsigned max_lat   = 0;
  logic [31:0] slow_addr = 32'h3;
  int unsigned slow_lat  = 0;
  bit          late_ack  = 1'b0;
  bit          busy      = 1'b0;
  int unsigned left      = 0;

  always @(posedge clk) begin
    #2;
    if (rst) begin
      busy = 1'b0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'h0;
    end else if (bus.imem_req) begin
      if (!busy) begin
        busy = 1'b1;
        left = (bus.imem_addr == slow_addr) ? slow_lat : $urandom_range(max_lat, 0);
      end
      if (left == 0) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        busy = 1'b0;
      end else begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
        left--;
      end
    end else begin
      busy = 1'b0;
      bus.imem_ack = late_ack;
      bus.imem_rdata = 32'hDEAD_BEEF;
    end
  end

  // Reference model: decode sees consecutive words from the last redirect target onward.
  logic [31:0] exp_q[$];
  logic [31:0] exp_next = 32'h0;
  bit          pending  = 1'b0;
  logic [31:0] pend_tgt = 32'h0;
  bit          prev_redir = 1'b0;
  bit          in_boot  = 1'b1;

  always @(negedge clk) begin
    logic        redir;
    logic [31:0] tgt, e, exp_pc;
    if (rst) begin
      exp_q.delete();
      exp_next   = 32'h0;
      pending    = 1'b0;
      prev_redir = 1'b0;
      in_boot    = 1'b1;
      check_eq("rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
      check_eq("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
    end else if (in_boot) begin
      in_boot = 1'b0;
      check_eq("boot_imem_req", {31'b0, bus.imem_req}, 32'h0);
      check_eq("boot_pc_stall", {31'b0, bus.pc_stall}, 32'h0);
      check_eq("boot_next_pc", bus.next_pc, 32'h0);
      check_eq("boot_if_valid", {31'b0, bus.if_valid}, 32'h0);
    end else begin
      redir = bus.exc | bus.eret | bus.jmp | bus.br_taken;
      tgt   = bus.exc ? 32'h80 : bus.eret ? bus.epc : bus.jmp ? bus.jmp_target : bus.br_target;
      if (prev_redir) check_eq("flush_if_valid", {31'b0, bus.if_valid}, 32'h0);
      if (bus.if_valid && !bus.id_stall) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(exp_next);
          exp_next += 32'd4;
        end
        e = exp_q.pop_front();
        check_eq("if_pc", bus.if_pc, e);
        check_eq("if_instr", bus.if_instr, mem_word(e));
        n_consumed++;
      end
      if (bus.imem_req) check_eq("imem_addr", bus.imem_addr, bus.pc);
      if (bus.imem_req && !bus.imem_ack) begin
        check_eq("wait_pc_stall", {31'b0, bus.pc_stall}, 32'h1);
        if (redir) begin
          pending  = 1'b1;
          pend_tgt = tgt;
        end
      end else if (bus.imem_req) begin
        exp_pc = redir ? tgt : (pending ? pend_tgt : bus.pc + 32'd4);
        check_eq("ack_pc_stall", {31'b0, bus.pc_stall}, 32'h0);
        check_eq("ack_next_pc", bus.next_pc, exp_pc);
        pending = 1'b0;
      end else if (redir) begin
        check_eq("idle_redir_stall", {31'b0, bus.pc_stall}, 32'h0);
        check_eq("idle_redir_next_pc", bus.next_pc, tgt);
      end else begin
        check_eq("idle_pc_stall", {31'b0, bus.pc_stall}, 32'h1);
      end
      if (redir) begin
        exp_q.delete();
        exp_q.push_back(tgt);
        exp_next = tgt + 32'd4;
      end
      prev_redir = redir;
    end
  end

  task automatic clear_redir();
    bus.exc = 1'b0; bus.eret = 1'b0; bus.jmp = 1'b0; bus.br_taken = 1'b0;
    bus.epc = 32'h0; bus.jmp_target = 32'h0; bus.br_target = 32'h0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the BOOT cycle; the next cyc() enters the first REQ cycle.
  task automatic do_reset(input int unsigned lat, input logic [31:0] saddr, input int unsigned slat);
    cyc();
    rst = 1'b1;
    clear_redir();
    bus.id_stall = 1'b0;
    max_lat = lat; slow_addr = saddr; slow_lat = slat;
    @(negedge clk);
    check_eq("rst_if_instr", bus.if_instr, 32'h0);
    check_eq("rst_if_pc", bus.if_pc, 32'h0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int unsigned start_cnt;
    rst = 1'b1;
    clear_redir();
    bus.id_stall = 1'b0;
    repeat (2) @(posedge clk);

    // Zero-wait memory: 0x0, 0x4, 0x8 back to back.
    do_reset(0, 32'h3, 0);
    cyc(); @(negedge clk);
    check_eq("zw_first_req", {31'b0, bus.imem_req}, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      cyc(); @(negedge clk);
      check_eq("zw_if_valid", {31'b0, bus.if_valid}, 32'h1);
      check_eq("zw_if_pc", bus.if_pc, 32'(4 * (i - 1)));
    end

    // Decode stall with 0x4 in the slot: 0x8 lands in the skid.
    do_reset(0, 32'h3, 0);
    cyc(); cyc();
    cyc(); bus.id_stall = 1'b1; @(negedge clk);
    check_eq("stall_if_pc", bus.if_pc, 32'h4);
    for (int i = 0; i < 2; i++) begin
      cyc(); @(negedge clk);
      check_eq("skid_no_req", {31'b0, bus.imem_req}, 32'h0);
      check_eq("skid_hold_pc", bus.if_pc, 32'h4);
    end
    cyc(); bus.id_stall = 1'b0; @(negedge clk);
    check_eq("release_if_pc", bus.if_pc, 32'h4);
    cyc(); @(negedge clk);
    check_eq("skid_to_slot", bus.if_pc, 32'h8);
    cyc(); @(negedge clk);
    check_eq("after_skid", bus.if_pc, 32'hC);

    // Branch while the 0x10 request waits two cycles.
    do_reset(0, 32'h10, 2);
    repeat (4) cyc();
    cyc(); bus.br_taken = 1'b1; bus.br_target = 32'h100; @(negedge clk);
    check_eq("drop_addr", bus.imem_addr, 32'h10);
    check_eq("drop_enter_stall", {31'b0, bus.pc_stall}, 32'h1);
    cyc(); clear_redir(); @(negedge clk);
    check_eq("drop_held_req", {31'b0, bus.imem_req}, 32'h1);
    check_eq("drop_if_valid", {31'b0, bus.if_valid}, 32'h0);
    cyc(); @(negedge clk);
    check_eq("drop_ack_next_pc", bus.next_pc, 32'h100);
    cyc(); @(negedge clk);
    check_eq("drop_pc", bus.pc, 32'h100);
    check_eq("drop_discarded", {31'b0, bus.if_valid}, 32'h0);
    cyc(); @(negedge clk);
    check_eq("drop_target_fetched", bus.if_pc, 32'h100);

    // Priority, eret, and PC wrap.
    do_reset(0, 32'h3, 0);
    cyc(); cyc();
    cyc();
    bus.exc = 1'b1; bus.jmp = 1'b1; bus.jmp_target = 32'h200;
    bus.br_taken = 1'b1; bus.br_target = 32'h300;
    @(negedge clk);
    check_eq("prio_next_pc", bus.next_pc, 32'h80);
    cyc(); clear_redir(); @(negedge clk);
    check_eq("prio_pc", bus.pc, 32'h80);
    cyc(); bus.eret = 1'b1; bus.epc = 32'h44; @(negedge clk);
    check_eq("eret_next_pc", bus.next_pc, 32'h44);
    cyc(); clear_redir();
    cyc(); bus.jmp = 1'b1; bus.jmp_target = 32'hFFFF_FFFC;
    cyc(); clear_redir(); @(negedge clk);
    check_eq("wrap_pc", bus.pc, 32'hFFFF_FFFC);
    check_eq("wrap_next_pc", bus.next_pc, 32'h0);
    repeat (3) cyc();

    // Reset between request and ack; a stray ack during BOOT must be ignored.
    do_reset(0, 32'h8, 3);
    repeat (3) cyc();
    cyc(); rst = 1'b1; #1;
    check_eq("midrst_imem_req", {31'b0, bus.imem_req}, 32'h0);
    check_eq("midrst_if_valid", {31'b0, bus.if_valid}, 32'h0);
    check_eq("midrst_next_pc", bus.next_pc, 32'h0);
    slow_addr = 32'h3;
    cyc(); rst = 1'b0; late_ack = 1'b1; @(negedge clk);
    check_eq("late_ack_if_valid", {31'b0, bus.if_valid}, 32'h0);
    cyc(); late_ack = 1'b0; @(negedge clk);
    check_eq("post_rst_addr", bus.imem_addr, 32'h0);
    check_eq("post_rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
    cyc(); @(negedge clk);
    check_eq("post_rst_if_pc", bus.if_pc, 32'h0);

    // Random traffic against the stream model.
    do_reset(3, 32'h3, 0);
    start_cnt = n_consumed;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      bus.id_stall = ($urandom_range(0, 9) < 4);
      clear_redir();
      if ($urandom_range(0, 99) < 6) begin
        logic [3:0] m;
        m = 4'($urandom_range(1, 15));
        bus.exc = m[0]; bus.eret = m[1]; bus.jmp = m[2]; bus.br_taken = m[3];
        bus.epc        = 32'($urandom_range(0, 1023)) << 2;
        bus.jmp_target = 32'($urandom_range(0, 1023)) << 2;
        bus.br_target  = 32'($urandom_range(0, 1023)) << 2;
      end
    end
    cyc(); clear_redir(); bus.id_stall = 1'b0;
    repeat (3) cyc();
    check_eq("random_progress", {31'b0, (n_consumed - start_cnt) >= 500}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
